// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule constants: S-box, Rcon table, round count, FSM encoding.
// Purely combinational lookups, so there is no latency and no flow control here.
package aes_pkg;

  localparam int AES_NR_128 = 10;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } ks_state_e;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Rcon is only defined for target rounds 1..10; anything else contributes nothing.
  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    logic [7:0] rc;
    rc = 8'h00;
    if (r >= 4'd1 && r <= 4'd10) rc = RCON[r];
    return rc;
  endfunction

endpackage

// File: rtl/key_expand_seq_sub_word.sv
// SubWord: byte-wise S-box substitution of one 32-bit word; combinational, no flow control.
// Byte 0 of the word is word_in[31:24], matching the key byte order.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] byte_in,
  output logic [7:0] byte_out
);
  assign byte_out = SBOX[byte_in];
endmodule

module sub_word (
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);
  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .byte_in  (word_in[8*b +: 8]),
      .byte_out (word_out[8*b +: 8])
    );
  end
endmodule

// File: rtl/key_expand_seq.sv
// Sequential AES-128 key schedule: one round key (0..NR) per valid/ready handshake, first key 1 cycle after start.
// Outputs hold while rk_ready is low; done pulses for one cycle after the last key is accepted.
module key_expand_seq
  import aes_pkg::*;
#(
  parameter int NR = AES_NR_128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         rk_ready,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         rk_valid,
  output logic         busy,
  output logic         done
);

  localparam logic [3:0] LAST_IDX = 4'(NR);

  ks_state_e    state_q, state_d;
  logic [127:0] round_key_q, round_key_d;
  logic [3:0]   round_idx_q, round_idx_d;
  logic         rk_valid_q, rk_valid_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot_w3, sub_w3, t_word;
  logic [31:0]  n0, n1, n2, n3;
  logic [3:0]   next_idx;
  logic         handshake;

  assign {w0, w1, w2, w3} = round_key_q;
  assign rot_w3   = {w3[23:0], w3[31:24]};
  assign next_idx = round_idx_q + 4'd1;

  sub_word u_sub_word (
    .word_in  (rot_w3),
    .word_out (sub_w3)
  );

  // Rcon is selected by the round being produced, not the one currently held.
  assign t_word = sub_w3 ^ {rcon_of(next_idx), 24'h000000};
  assign n0 = w0 ^ t_word;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign handshake = rk_valid_q && rk_ready;

  always_comb begin
    state_d     = state_q;
    round_key_d = round_key_q;
    round_idx_d = round_idx_q;
    rk_valid_d  = rk_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = ACTIVE;
          round_key_d = key_in;
          round_idx_d = 4'd0;
          rk_valid_d  = 1'b1;
          busy_d      = 1'b1;
        end
      end
      ACTIVE: begin
        if (handshake) begin
          if (round_idx_q == LAST_IDX) begin
            // Key and index stay put so the consumer can still see the last key.
            state_d    = IDLE;
            rk_valid_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
          end else begin
            round_key_d = {n0, n1, n2, n3};
            round_idx_d = next_idx;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      round_key_q <= '0;
      round_idx_q <= '0;
      rk_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_key_q <= round_key_d;
      round_idx_q <= round_idx_d;
      rk_valid_q  <= rk_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign round_key = round_key_q;
  assign round_idx = round_idx_q;
  assign rk_valid  = rk_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_key_expand_seq.sv
// Bench for key_expand_seq: scoreboard of model round keys plus FIPS-197 anchors,
// covering back-to-back, random backpressure, ignored start, mid-run reset and NR=2.
module tb_key_expand_seq;

  localparam logic [127:0] KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1_K1    = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A1_K10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Z_K1     = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z_K10    = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [127:0] KEY_ALT  = 128'h000102030405060708090a0b0c0d0e0f;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         rk_ready;

  logic [127:0] rk_a, rk_b;
  logic [3:0]   idx_a, idx_b;
  logic         vld_a, vld_b, busy_a, busy_b, done_a, done_b;

  logic         sel;
  logic [127:0] o_key;
  logic [3:0]   o_idx;
  logic         o_vld, o_busy, o_done;

  key_expand_seq #(.NR(10)) dut (
    .clk (clk), .rst (rst), .start (start), .key_in (key_in), .rk_ready (rk_ready),
    .round_key (rk_a), .round_idx (idx_a), .rk_valid (vld_a), .busy (busy_a), .done (done_a)
  );

  key_expand_seq #(.NR(2)) dut_nr2 (
    .clk (clk), .rst (rst), .start (start), .key_in (key_in), .rk_ready (rk_ready),
    .round_key (rk_b), .round_idx (idx_b), .rk_valid (vld_b), .busy (busy_b), .done (done_b)
  );

  assign o_key  = sel ? rk_b   : rk_a;
  assign o_idx  = sel ? idx_b  : idx_a;
  assign o_vld  = sel ? vld_b  : vld_a;
  assign o_busy = sel ? busy_b : busy_a;
  assign o_done = sel ? done_b : done_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int           idx;
    logic [127:0] key;
  } exp_t;

  exp_t         exp_q[$];
  logic [7:0]   sb_ref [256];
  int           n_checks = 0;
  int           n_pass   = 0;
  bit           fips_en;
  logic [127:0] fips_k1, fips_k10;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
  endtask

  // Independent model: S-box derived from GF(2^8) inversion plus the affine map.
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] calc_sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int i = 1; i < 256; i++)
      if (x != 8'h00 && gmul(x, 8'(i)) == 8'h01) inv = 8'(i);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] ref_next(input logic [127:0] k, input int r);
    logic [31:0] w[4];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 1; i < r; i++) rc = gmul(rc, 8'h02);
    t = {w[3][23:0], w[3][31:24]};
    t = {sb_ref[t[31:24]], sb_ref[t[23:16]], sb_ref[t[15:8]], sb_ref[t[7:0]]} ^ {rc, 24'h0};
    w[0] = w[0] ^ t;
    w[1] = w[1] ^ w[0];
    w[2] = w[2] ^ w[1];
    w[3] = w[3] ^ w[2];
    return {w[0], w[1], w[2], w[3]};
  endfunction

  // Called at a negedge: drives start for one edge and loads the scoreboard.
  task automatic start_exp(input logic [127:0] k, input int nr);
    exp_t e;
    logic [127:0] cur;
    exp_q.delete();
    cur = k;
    for (int r = 0; r <= nr; r++) begin
      if (r > 0) cur = ref_next(cur, r);
      e.idx = r; e.key = cur;
      exp_q.push_back(e);
    end
    start  = 1'b1;
    key_in = k;
    @(negedge clk);
    start = 1'b0;
    chk("first_valid", 128'(o_vld), 128'(1));
    chk("first_busy", 128'(o_busy), 128'(1));
  endtask

  // inj_kind: 0 none, 1 start with another key at inj_idx, 2 reset at inj_idx.
  task automatic drain(input int nr, input bit rnd, input int inj_kind, input int inj_idx);
    exp_t         e;
    bit           fin, holding;
    int           budget;
    logic [127:0] hold_k;
    logic [3:0]   hold_i;
    fin = 0; holding = 0; budget = 300;
    while (!fin && budget > 0) begin
      budget--;
      if (holding) begin
        chk("hold_key", o_key, hold_k);
        chk("hold_idx", 128'(o_idx), 128'(hold_i));
        holding = 0;
      end
      if (inj_kind == 2 && int'(o_idx) == inj_idx) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_valid", 128'(o_vld), 128'(0));
        chk("rst_busy", 128'(o_busy), 128'(0));
        chk("rst_done", 128'(o_done), 128'(0));
        chk("rst_idx", 128'(o_idx), 128'(0));
        exp_q.delete();
        return;
      end
      start  = (inj_kind == 1 && int'(o_idx) == inj_idx);
      if (start) key_in = KEY_ALT;
      rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      chk("act_valid", 128'(o_vld), 128'(1));
      chk("act_busy", 128'(o_busy), 128'(1));
      if (rk_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 128'(o_idx), 128'hffff);
          fin = 1;
        end else begin
          e = exp_q.pop_front();
          chk("sb_idx", 128'(o_idx), 128'(e.idx));
          chk("sb_key", o_key, e.key);
          if (fips_en && e.idx == 1) chk("fips_idx1", o_key, fips_k1);
          if (fips_en && e.idx == 10) chk("fips_idx10", o_key, fips_k10);
          if (e.idx == nr) fin = 1;
        end
      end else begin
        hold_k = o_key; hold_i = o_idx; holding = 1;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (!fin) chk("drain_timeout", 128'(budget), 128'(1));
    chk("done_pulse", 128'(o_done), 128'(1));
    chk("end_valid", 128'(o_vld), 128'(0));
    chk("end_busy", 128'(o_busy), 128'(0));
    chk("end_idx", 128'(o_idx), 128'(nr));
  endtask

  task automatic idle_check();
    rk_ready = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", 128'(o_done), 128'(0));
    chk("idle_valid", 128'(o_vld), 128'(0));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; key_in = '0; rk_ready = 1'b0; sel = 1'b0; fips_en = 0;
    fips_k1 = '0; fips_k10 = '0;
    for (int i = 0; i < 256; i++) sb_ref[i] = calc_sbox(8'(i));
    @(negedge clk);
    @(negedge clk);
    chk("reset_key", o_key, 128'h0);
    chk("reset_idx", 128'(o_idx), 128'(0));
    chk("reset_valid", 128'(o_vld), 128'(0));
    chk("reset_busy", 128'(o_busy), 128'(0));
    chk("reset_done", 128'(o_done), 128'(0));
    rst = 1'b0;
    @(negedge clk);

    // A.1 back-to-back, then a new start in the done cycle with the all-zero key
    fips_en = 1; fips_k1 = A1_K1; fips_k10 = A1_K10;
    rk_ready = 1'b1;
    start_exp(KEY_A1, 10);
    drain(10, 0, 0, 0);
    fips_k1 = Z_K1; fips_k10 = Z_K10;
    start_exp(128'h0, 10);
    chk("done_cycle_start_idx", 128'(o_idx), 128'(0));
    drain(10, 0, 0, 0);
    idle_check();

    // random backpressure on A.1
    fips_k1 = A1_K1; fips_k10 = A1_K10;
    start_exp(KEY_A1, 10);
    drain(10, 1, 0, 0);
    idle_check();

    // start with a different key at idx 4 must be ignored
    start_exp(KEY_A1, 10);
    drain(10, 0, 1, 4);
    idle_check();

    // reset at idx 6, then a clean full run
    start_exp(KEY_A1, 10);
    drain(10, 0, 2, 6);
    start_exp(KEY_A1, 10);
    drain(10, 0, 0, 0);
    idle_check();

    // NR=2 instance
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sel = 1'b1;
    fips_en = 1; fips_k1 = A1_K1; fips_k10 = A1_K10;
    start_exp(KEY_A1, 2);
    drain(2, 0, 0, 0);
    idle_check();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/key_expand_seq.md
Name: key_expand_seq

Overview:
Sequential AES-128 key schedule that sits upstream of the round datapath (AddRoundKey, then SubBytes).
- Accepts a 128-bit cipher key and emits round keys 0..NR, one per handshake, over a valid/ready interface.
- Next-word generation uses SubWord, built from four sBox lookups, plus RotWord and Rcon.
- One round key is produced per cycle when the consumer is ready.

Parameters:
NR, 10, number of rounds; legal range 1..10; round keys 0..NR are emitted.

Ports:
clk  in  1  rising-edge clock; the only clock.
rst  in  1  reset; synchronous, active-high.
start  in  1  request to expand key_in; sampled only in IDLE.
key_in  in  128  cipher key; byte 0 is key_in[127:120]; w0 = key_in[127:96].
rk_ready  in  1  consumer accepts round_key this cycle.
round_key  out  128  current round key, same byte order as key_in.
round_idx  out  4  index of round_key, 0..NR.
rk_valid  out  1  round_key/round_idx valid.
busy  out  1  expansion in progress.
done  out  1  one-cycle pulse after the final round key is accepted.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state goes to IDLE.
  - round_key, round_idx, rk_valid, busy and done all go to 0.
  - Applies at any time, including mid-expansion; the in-flight expansion is discarded.
- States: IDLE and ACTIVE.
- IDLE:
  - rk_valid=0, busy=0.
  - start=1 at edge T: register key_in into round_key, round_idx<=0, go to ACTIVE.
  - At T+1: rk_valid=1, busy=1. Start-to-first-key latency is 1 cycle.
  - key_in is sampled only at T.
- ACTIVE:
  - rk_valid=1, busy=1.
  - Handshake occurs at an edge where rk_valid&&rk_ready.
  - Handshake with round_idx<NR: round_key <= next key; round_idx <= round_idx+1. Back-to-back handshakes give one key per cycle.
  - Handshake with round_idx==NR: go to IDLE; rk_valid<=0, busy<=0, done<=1 for exactly one cycle. round_key/round_idx keep their last values.
  - No handshake (rk_ready=0): round_key, round_idx and rk_valid hold stable. No bubbles and no skipped keys.
- start while ACTIVE is ignored; key_in is not re-sampled.
- start in the same cycle that done=1 (state already IDLE) is accepted normally.
- Next-key arithmetic (current key words w0..w3, r = round_idx+1):
  - t = SubWord(RotWord(w3)) ^ {Rcon[r],24'h0}.
  - RotWord(x) = {x[23:0], x[31:24]}.
  - SubWord applies sBox to each byte.
  - n0=w0^t, n1=w1^n0, n2=w2^n1, n3=w3^n2.
  - next key = {n0,n1,n2,n3}.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36. Rcon is indexed by the target round, never by round 0.
- round_idx never exceeds NR and never wraps.
- Critical path: register -> sBox -> XOR chain -> register. No multicycle paths.

Decomposition:
- Shared package aes_pkg holds:
  - the Rcon constant table (10 x 8-bit);
  - localparam AES_NR_128 = 10;
  - the state encoding IDLE/ACTIVE.
- Sub-module sub_word: 32-bit in / 32-bit out, four sBox instances. The block's word and byte ordering is defined in the next-key arithmetic above.
- key_expand_seq holds the FSM, registers, RotWord, Rcon XOR and the word XOR chain.

Test Plan:
- FIPS-197 A.1 vector, rk_ready=1 constantly: key 2b7e151628aed2a6abf7158809cf4f3c.
  - Response: idx0 = key; idx1 = a0fafe1788542cb123a339392a6c7605; idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - 11 consecutive valid cycles; done pulses on the cycle after idx10 is accepted.
- All-zero key:
  - Response: idx1 = 62636363626363636263636362636363; idx10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Backpressure: rk_ready random ~50% on the A.1 key.
  - Response: identical 11-key sequence, no duplicates or skips; outputs stable while rk_ready=0.
- start pulsed with a different key at idx 4, during ACTIVE:
  - Response: ignored; sequence continues from the original key.
  - start in the done cycle begins a new expansion; first key valid the next cycle.
- rst asserted at idx 6:
  - Response: next cycle rk_valid=0, busy=0, done=0, round_idx=0.
  - A subsequent start yields a correct full sequence.
- NR=2 instance:
  - Response: exactly keys idx0..2 (A.1 values); done after idx2.
